// File: rtl/monitor_semafor_if.sv
// Lamp read-back and fault-report signals between the intersection and its
// conflict monitor.
interface monitor_semafor_if;
   logic [3:0] verde_i;
   logic [3:0] galben_i;
   logic [3:0] rosu_i;
   logic [3:0] verde_pietoni_i;
   logic [3:0] rosu_pietoni_i;
   logic       service_i;
   logic       fault_clr_i;
   logic       armed_o;
   logic       fault_o;
   logic [2:0] fault_cod_o;
   logic [1:0] fault_dir_o;
   logic       service_req_o;

   modport master (
      output verde_i, galben_i, rosu_i, verde_pietoni_i, rosu_pietoni_i,
      output service_i, fault_clr_i,
      input  armed_o, fault_o, fault_cod_o, fault_dir_o, service_req_o
   );

   modport slave (
      input  verde_i, galben_i, rosu_i, verde_pietoni_i, rosu_pietoni_i,
      input  service_i, fault_clr_i,
      output armed_o, fault_o, fault_cod_o, fault_dir_o, service_req_o
   );
endinterface

// File: rtl/monitor_semafor.sv
// Conflict monitor: debounces the 20 lamp read-backs and latches the first
// illegal combination, conflicting green, bad sequence or timing violation.
module monitor_semafor #(
   parameter int FACTOR_DIVIZARE = 1000,
   parameter int MIN_GALBEN_SEC  = 3,
   parameter int MAX_VERDE_SEC   = 60,
   parameter int GLITCH_CYC      = 4
) (
   input logic              clk,
   input logic              rst_n,
   monitor_semafor_if.slave bus
);
   localparam int PW = (FACTOR_DIVIZARE > 1) ? $clog2(FACTOR_DIVIZARE) : 1;
   localparam int DW = $clog2(MAX_VERDE_SEC + 2);
   localparam int GW = $clog2(GLITCH_CYC + 1);
   localparam logic [PW-1:0] PRE_LAST   = PW'(FACTOR_DIVIZARE - 1);
   localparam logic [DW-1:0] DUR_SAT    = DW'(MAX_VERDE_SEC + 1);
   localparam logic [DW-1:0] GALBEN_MIN = DW'((MIN_GALBEN_SEC > 0) ? MIN_GALBEN_SEC - 1 : 0);
   localparam logic [GW-1:0] RUN_FULL   = GW'(GLITCH_CYC);
   // Pattern bits: {verde_pietoni, rosu_pietoni, rosu, galben, verde}
   localparam logic [4:0]    RED_PAT    = 5'b01100;

   typedef enum logic [1:0] {PH_R = 2'd0, PH_G = 2'd1, PH_Y = 2'd2} faza_t;
   typedef enum logic [1:0] {
      ST_SYNC = 2'd0, ST_MONITOR = 2'd1, ST_FAULT = 2'd2, ST_SERVICE = 2'd3
   } state_t;

   function automatic logic one_hot3(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

   function automatic logic legal_step(input faza_t from, input faza_t to);
      return ((from == PH_R) && (to == PH_G)) ||
             ((from == PH_G) && (to == PH_Y)) ||
             ((from == PH_Y) && (to == PH_R));
   endfunction

   function automatic logic [1:0] lowest_idx(input logic [3:0] m);
      logic [1:0] r;
      if (m[0])      r = 2'd0;
      else if (m[1]) r = 2'd1;
      else if (m[2]) r = 2'd2;
      else           r = 2'd3;
      return r;
   endfunction

   logic [4:0]    raw_s    [4];
   logic [4:0]    prev_q   [4];
   logic [4:0]    stable_q [4];
   logic [GW-1:0] run_q    [4];
   logic [GW-1:0] run_d    [4];
   logic [PW-1:0] pre_q;
   logic          tick_s;
   faza_t         ph_q     [4];
   faza_t         ph_d     [4];
   logic [DW-1:0] dur_q    [4];
   logic [DW-1:0] dur_d    [4];
   logic [3:0]    act_s, vp_s;
   logic [3:0]    m_lampa_s, m_conf_s, m_secv_s, m_scurt_s, m_lung_s;
   logic          all_red_s, multi_s, viol_s;
   logic [2:0]    cod_s;
   logic [1:0]    dir_s;
   state_t        state_q;
   logic          armed_q, fault_q, svc_req_q;
   logic [2:0]    cod_q;
   logic [1:0]    dir_q;

   // Run length of the current raw pattern per approach
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         raw_s[i] = {bus.verde_pietoni_i[i], bus.rosu_pietoni_i[i], bus.rosu_i[i],
                     bus.galben_i[i], bus.verde_i[i]};
         if (raw_s[i] != prev_q[i]) begin
            run_d[i] = GW'(1'b1);
         end else if (run_q[i] != RUN_FULL) begin
            run_d[i] = run_q[i] + GW'(1'b1);
         end else begin
            run_d[i] = run_q[i];
         end
      end
   end

   // Glitch filter: adopt a pattern once it has been seen GLITCH_CYC edges in a row
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            prev_q[i]   <= 5'd0;
            run_q[i]    <= {GW{1'b0}};
            stable_q[i] <= 5'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            prev_q[i] <= raw_s[i];
            run_q[i]  <= run_d[i];
            if (run_d[i] == RUN_FULL) begin
               stable_q[i] <= raw_s[i];
            end
         end
      end
   end

   assign tick_s = (pre_q == PRE_LAST);

   // Phase decode and per-phase duration; malformed patterns keep the last phase
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         case (stable_q[i][2:0])
            3'b001:  ph_d[i] = PH_G;
            3'b010:  ph_d[i] = PH_Y;
            3'b100:  ph_d[i] = PH_R;
            default: ph_d[i] = ph_q[i];
         endcase
         if (ph_d[i] != ph_q[i]) begin
            dur_d[i] = {DW{1'b0}};
         end else if (tick_s && (dur_q[i] != DUR_SAT)) begin
            dur_d[i] = dur_q[i] + DW'(1'b1);
         end else begin
            dur_d[i] = dur_q[i];
         end
      end
   end

   // Prescaler, phase and duration registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q <= {PW{1'b0}};
         for (int i = 0; i < 4; i++) begin
            ph_q[i]  <= PH_R;
            dur_q[i] <= {DW{1'b0}};
         end
      end else begin
         pre_q <= tick_s ? {PW{1'b0}} : pre_q + PW'(1'b1);
         for (int i = 0; i < 4; i++) begin
            ph_q[i]  <= ph_d[i];
            dur_q[i] <= dur_d[i];
         end
      end
   end

   // Violation masks and first-fault selection: lowest code, then lowest approach
   always_comb begin
      all_red_s = 1'b1;
      for (int i = 0; i < 4; i++) begin
         act_s[i]  = stable_q[i][0] | stable_q[i][1];
         vp_s[i]   = stable_q[i][4];
         all_red_s = all_red_s & (stable_q[i] == RED_PAT);
      end
      multi_s = ((act_s & (act_s - 4'd1)) != 4'd0);
      for (int i = 0; i < 4; i++) begin
         m_lampa_s[i] = !one_hot3(stable_q[i][2:0]) || (stable_q[i][4] == stable_q[i][3]);
         m_conf_s[i]  = (act_s[i] && (multi_s || vp_s[i] || ((vp_s & ~(4'd1 << i)) != 4'd0))) ||
                        (vp_s[i] && ((act_s & ~(4'd1 << i)) != 4'd0));
         m_secv_s[i]  = (ph_d[i] != ph_q[i]) && !legal_step(ph_q[i], ph_d[i]);
         m_scurt_s[i] = (ph_q[i] == PH_Y) && (ph_d[i] == PH_R) && (dur_q[i] < GALBEN_MIN);
         m_lung_s[i]  = (ph_q[i] == PH_G) && (dur_q[i] == DUR_SAT);
      end
      if (m_lampa_s != 4'd0) begin
         cod_s = 3'd1;
         dir_s = lowest_idx(m_lampa_s);
      end else if (m_conf_s != 4'd0) begin
         cod_s = 3'd2;
         dir_s = lowest_idx(m_conf_s);
      end else if (m_secv_s != 4'd0) begin
         cod_s = 3'd3;
         dir_s = lowest_idx(m_secv_s);
      end else if (m_scurt_s != 4'd0) begin
         cod_s = 3'd4;
         dir_s = lowest_idx(m_scurt_s);
      end else if (m_lung_s != 4'd0) begin
         cod_s = 3'd5;
         dir_s = lowest_idx(m_lung_s);
      end else begin
         cod_s = 3'd0;
         dir_s = 2'd0;
      end
      viol_s = (cod_s != 3'd0);
   end

   // Monitor FSM with registered outputs; a fault outranks entry into service
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_SYNC;
         armed_q   <= 1'b0;
         fault_q   <= 1'b0;
         svc_req_q <= 1'b0;
         cod_q     <= 3'd0;
         dir_q     <= 2'd0;
      end else begin
         case (state_q)
            ST_SYNC: begin
               if (all_red_s && !bus.service_i) begin
                  state_q <= ST_MONITOR;
                  armed_q <= 1'b1;
               end
            end
            ST_MONITOR: begin
               if (viol_s) begin
                  state_q   <= ST_FAULT;
                  armed_q   <= 1'b0;
                  fault_q   <= 1'b1;
                  svc_req_q <= 1'b1;
                  cod_q     <= cod_s;
                  dir_q     <= dir_s;
               end else if (bus.service_i) begin
                  state_q <= ST_SERVICE;
                  armed_q <= 1'b0;
               end
            end
            ST_FAULT: begin
               if (bus.fault_clr_i) begin
                  state_q   <= ST_SYNC;
                  fault_q   <= 1'b0;
                  svc_req_q <= 1'b0;
                  cod_q     <= 3'd0;
                  dir_q     <= 2'd0;
               end
            end
            ST_SERVICE: begin
               if (!bus.service_i) begin
                  state_q <= ST_SYNC;
               end
            end
            default: begin
               state_q   <= ST_SYNC;
               armed_q   <= 1'b0;
               fault_q   <= 1'b0;
               svc_req_q <= 1'b0;
               cod_q     <= 3'd0;
               dir_q     <= 2'd0;
            end
         endcase
      end
   end

   assign bus.armed_o       = armed_q;
   assign bus.fault_o       = fault_q;
   assign bus.fault_cod_o   = cod_q;
   assign bus.fault_dir_o   = dir_q;
   assign bus.service_req_o = svc_req_q;
endmodule

// File: tb/tb_monitor_semafor.sv
// Directed plus randomized bench for monitor_semafor, checked every cycle
// against a rule-level model of the monitor.
module tb_monitor_semafor;
   localparam int F    = 10;
   localparam int MING = 3;
   localparam int MAXV = 6;
   localparam int GC   = 4;
   // Bench lamp word: bit0 verde, bit1 galben, bit2 rosu, bit3 rosu_pietoni, bit4 verde_pietoni
   localparam logic [4:0] P_R  = 5'b01100;
   localparam logic [4:0] P_G  = 5'b01001;
   localparam logic [4:0] P_Y  = 5'b01010;
   localparam int ST_SYNC = 0, ST_MON = 1, ST_FAULT = 2, ST_SERV = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] pat [4];
   logic       svc = 1'b0;
   logic       clr = 1'b0;
   int         n_cmp = 0;
   int         n_err = 0;

   logic [4:0] m_last [4];
   logic [4:0] m_stab [4];
   int         m_run  [4];
   int         m_ph   [4];
   int         m_dur  [4];
   int         m_edges, m_st;
   logic       e_armed, e_fault;
   logic [2:0] e_cod;
   logic [1:0] e_dir;

   always #5 clk = ~clk;

   monitor_semafor_if bus ();
   assign bus.verde_i         = {pat[3][0], pat[2][0], pat[1][0], pat[0][0]};
   assign bus.galben_i        = {pat[3][1], pat[2][1], pat[1][1], pat[0][1]};
   assign bus.rosu_i          = {pat[3][2], pat[2][2], pat[1][2], pat[0][2]};
   assign bus.rosu_pietoni_i  = {pat[3][3], pat[2][3], pat[1][3], pat[0][3]};
   assign bus.verde_pietoni_i = {pat[3][4], pat[2][4], pat[1][4], pat[0][4]};
   assign bus.service_i       = svc;
   assign bus.fault_clr_i     = clr;

   monitor_semafor #(
      .FACTOR_DIVIZARE(F), .MIN_GALBEN_SEC(MING), .MAX_VERDE_SEC(MAXV), .GLITCH_CYC(GC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   // 0 = R, 1 = G, 2 = Y, -1 = not a single vehicle lamp
   function automatic int phase_of(input logic [4:0] p);
      if (p[2:0] == 3'b100) return 0;
      if (p[2:0] == 3'b001) return 1;
      if (p[2:0] == 3'b010) return 2;
      return -1;
   endfunction

   function automatic bit moving(input int j);
      return (m_stab[j][0] | m_stab[j][1]) == 1'b1;
   endfunction

   function automatic bit viol(input int c, input int d);
      int np, nact;
      bit oth_act, oth_vp;
      np = phase_of(m_stab[d]);
      if (np < 0) np = m_ph[d];
      nact = 0; oth_act = 0; oth_vp = 0;
      for (int j = 0; j < 4; j++) begin
         if (moving(j)) nact++;
         if (j != d && moving(j)) oth_act = 1;
         if (j != d && m_stab[j][4]) oth_vp = 1;
      end
      case (c)
         1: return ($countones(m_stab[d][2:0]) != 1) || ($countones(m_stab[d][4:3]) != 1);
         2: return (moving(d) && (nact > 1 || m_stab[d][4] || oth_vp)) || (m_stab[d][4] && oth_act);
         3: return (np != m_ph[d]) && !((m_ph[d] == 0 && np == 1) || (m_ph[d] == 1 && np == 2) ||
                                        (m_ph[d] == 2 && np == 0));
         4: return (m_ph[d] == 2) && (np == 0) && (m_dur[d] < MING - 1);
         5: return (m_ph[d] == 1) && (m_dur[d] >= MAXV + 1);
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_last[i] = 5'd0; m_stab[i] = 5'd0; m_run[i] = 0; m_ph[i] = 0; m_dur[i] = 0;
      end
      m_edges = 0; m_st = ST_SYNC;
      e_armed = 1'b0; e_fault = 1'b0; e_cod = 3'd0; e_dir = 2'd0;
   endtask

   task automatic model_edge();
      bit tick, all_red;
      int vc, vd, np;
      tick = (m_edges % F) == (F - 1);
      m_edges++;
      vc = 0; vd = 0; all_red = 1;
      for (int c = 1; c <= 5; c++)
         for (int d = 0; d < 4; d++)
            if (vc == 0 && viol(c, d)) begin vc = c; vd = d; end
      for (int d = 0; d < 4; d++) if (m_stab[d] != P_R) all_red = 0;
      case (m_st)
         ST_SYNC:  if (all_red && !svc) m_st = ST_MON;
         ST_MON:   if (vc != 0) begin m_st = ST_FAULT; e_cod = 3'(vc); e_dir = 2'(vd); end
                   else if (svc) m_st = ST_SERV;
         ST_FAULT: if (clr) begin m_st = ST_SYNC; e_cod = 3'd0; e_dir = 2'd0; end
         default:  if (!svc) m_st = ST_SYNC;
      endcase
      e_armed = (m_st == ST_MON);
      e_fault = (m_st == ST_FAULT);
      for (int d = 0; d < 4; d++) begin
         np = phase_of(m_stab[d]);
         if (np < 0) np = m_ph[d];
         if (np != m_ph[d]) begin m_ph[d] = np; m_dur[d] = 0; end
         else if (tick && m_dur[d] < MAXV + 1) m_dur[d]++;
      end
      for (int d = 0; d < 4; d++) begin
         if (pat[d] == m_last[d]) begin if (m_run[d] < GC) m_run[d]++; end
         else m_run[d] = 1;
         m_last[d] = pat[d];
         if (m_run[d] >= GC) m_stab[d] = pat[d];
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("armed", 8'(bus.armed_o), 8'(e_armed));
      chk("fault", 8'(bus.fault_o), 8'(e_fault));
      chk("cod", 8'(bus.fault_cod_o), 8'(e_cod));
      chk("dir", 8'(bus.fault_dir_o), 8'(e_dir));
      chk("svc_req", 8'(bus.service_req_o), 8'(e_fault));
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         model_edge();
         #1 check_model();
      end
   endtask

   task automatic set_all(input logic [4:0] p);
      for (int i = 0; i < 4; i++) pat[i] = p;
   endtask

   task automatic pulse_clr();
      clr = 1'b1; step(1); clr = 1'b0;
   endtask

   task automatic arm();
      set_all(P_R); svc = 1'b0; step(GC + 1);
      chk("arm", 8'(bus.armed_o), 8'd1);
   endtask

   initial begin
      set_all(P_R);
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_model();
      chk("rst_fault", 8'(bus.fault_o), 8'd0);
      #1 rst_n = 1'b1;

      // Arming latency after reset
      step(GC);
      chk("arm_early", 8'(bus.armed_o), 8'd0);
      step(1);
      chk("arm_now", 8'(bus.armed_o), 8'd1);
      chk("arm_cod", 8'(bus.fault_cod_o), 8'd0);

      // Legal cycles on nord then sud
      for (int a = 0; a < 2; a++) begin
         pat[a] = P_G; step(5 * F);
         pat[a] = P_Y; step(3 * F);
         pat[a] = P_R; step(F);
      end
      chk("legal_armed", 8'(bus.armed_o), 8'd1);
      chk("legal_fault", 8'(bus.fault_o), 8'd0);

      // Conflicting greens nord + est
      pat[0] = P_G; pat[2] = P_G;
      step(GC);
      chk("conf_early", 8'(bus.fault_o), 8'd0);
      step(1);
      chk("conf_fault", 8'(bus.fault_o), 8'd1);
      chk("conf_cod", 8'(bus.fault_cod_o), 8'd2);
      chk("conf_dir", 8'(bus.fault_dir_o), 8'd0);
      chk("conf_req", 8'(bus.service_req_o), 8'd1);
      pulse_clr();
      chk("clr_fault", 8'(bus.fault_o), 8'd0);
      chk("clr_armed", 8'(bus.armed_o), 8'd0);
      arm();

      // Short yellow on vest
      pat[3] = P_G; step(2 * F);
      pat[3] = P_Y; step(F);
      pat[3] = P_R; step(GC + 1);
      chk("scurt_cod", 8'(bus.fault_cod_o), 8'd4);
      chk("scurt_dir", 8'(bus.fault_dir_o), 8'd3);
      pulse_clr();
      arm();

      // 2-cycle glitch on sud is filtered out
      pat[1] = 5'b01101; step(2);
      pat[1] = P_R; step(GC + 2);
      chk("glitch", 8'(bus.fault_o), 8'd0);

      // Long green on est, then service and reset while faulted
      pat[2] = P_G; step(8 * F);
      chk("lung_cod", 8'(bus.fault_cod_o), 8'd5);
      chk("lung_dir", 8'(bus.fault_dir_o), 8'd2);
      svc = 1'b1; step(3);
      chk("svc_in_fault", 8'(bus.fault_o), 8'd1);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_model();
      chk("midrst_fault", 8'(bus.fault_o), 8'd0);
      chk("midrst_cod", 8'(bus.fault_cod_o), 8'd0);
      svc = 1'b0; set_all(P_R);
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
      arm();

      // Direct G->R on sud together with malformed nord lamps
      pat[1] = P_G; step(2 * F);
      pat[1] = P_R; pat[0] = 5'b01011; step(GC + 1);
      chk("prio_cod", 8'(bus.fault_cod_o), 8'd1);
      chk("prio_dir", 8'(bus.fault_dir_o), 8'd0);
      pulse_clr();
      arm();

      // Service suspends checking; exit requires all-red again
      svc = 1'b1; step(2);
      chk("svc_armed", 8'(bus.armed_o), 8'd0);
      pat[0] = P_G; pat[2] = P_G; step(20);
      chk("svc_nofault", 8'(bus.fault_o), 8'd0);
      svc = 1'b0; step(5);
      chk("svc_sync", 8'(bus.armed_o), 8'd0);
      arm();

      // Randomized episodes against the model
      for (int ep = 0; ep < 60; ep++) begin
         int r, a;
         r = $urandom_range(0, 9);
         a = $urandom_range(0, 3);
         if (r <= 5) begin
            if (pat[a] == P_R)      pat[a] = P_G;
            else if (pat[a] == P_G) pat[a] = P_Y;
            else                    pat[a] = P_R;
         end else if (r == 6) begin
            pat[a] = 5'($urandom_range(0, 31));
         end else if (r == 7) begin
            pulse_clr();
         end else if (r == 8) begin
            svc = ~svc;
         end else begin
            set_all(P_R);
         end
         step($urandom_range(1, 25));
      end
      svc = 1'b0;
      pulse_clr();
      arm();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
